// File: rtl/f_mux_arbiter_if.sv
// rtl/f_mux_arbiter_if.sv - requester/mux-side bundle for the F-mux round-robin arbiter
interface f_mux_arbiter_if;
  logic REQ1;
  logic REQ2;
  logic F1;
  logic F2;
  logic GNT1;
  logic GNT2;
  logic FS;
  logic FZ;
  logic BUSY;

  // fabric side: raises requests and presents mux data
  modport master (
    output REQ1, REQ2, F1, F2,
    input  GNT1, GNT2, FS, FZ, BUSY
  );

  // arbiter side: owns the select line and the registered mux result
  modport slave (
    input  REQ1, REQ2, F1, F2,
    output GNT1, GNT2, FS, FZ, BUSY
  );
endinterface

// File: rtl/f_mux_arbiter.sv
// rtl/f_mux_arbiter.sv - two-requester round-robin arbiter driving one F-mux select; optional FMUX_ARB_TIMEOUT_EN hold limit
module f_mux_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic           QCK,
  input logic           QRT,
  f_mux_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2,
    SWITCH = 2'd3
  } state_t;

  state_t state;
  // side encoding: 0 = requester 1 / F1, 1 = requester 2 / F2
  logic   last;
  logic   tgt;

  logic   any_req;
  logic   win;
  logic   own_req;
  logic   other_req;
  logic   tgt_req;
  logic   revoke;

`ifdef FMUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
`endif

  // winner selection and per-state request views
  always_comb begin
    any_req   = bus.REQ1 | bus.REQ2;
    // on a tie the side that did not hold the grant last wins
    win       = (bus.REQ1 & bus.REQ2) ? ~last : bus.REQ2;
    own_req   = (state == GRANT2) ? bus.REQ2 : bus.REQ1;
    other_req = (state == GRANT2) ? bus.REQ1 : bus.REQ2;
    tgt_req   = tgt ? bus.REQ2 : bus.REQ1;
`ifdef FMUX_ARB_TIMEOUT_EN
    // the edge that would bring the count to MAX_HOLD revokes instead
    revoke    = other_req && (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
    revoke    = 1'b0;
`endif
  end

  // arbitration FSM with registered grants, select, busy and mux result
  always_ff @(posedge QCK) begin
    if (QRT) begin
      state    <= IDLE;
      last     <= 1'b1;
      tgt      <= 1'b0;
      bus.GNT1 <= 1'b0;
      bus.GNT2 <= 1'b0;
      bus.FS   <= 1'b0;
      bus.FZ   <= 1'b0;
      bus.BUSY <= 1'b0;
`ifdef FMUX_ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      // mux result uses the select already on the line, so it lags FS by one cycle
      bus.FZ <= bus.FS ? bus.F2 : bus.F1;

      case (state)
        IDLE: begin
          if (any_req) begin
            bus.BUSY <= 1'b1;
            if (win == bus.FS) begin
              // select already points at the winner: grant directly
              state    <= win ? GRANT2 : GRANT1;
              bus.GNT1 <= ~win;
              bus.GNT2 <= win;
`ifdef FMUX_ARB_TIMEOUT_EN
              hold_cnt <= '0;
`endif
            end else begin
              // move the select first, grant on the following edge
              state  <= SWITCH;
              bus.FS <= win;
              tgt    <= win;
            end
          end else begin
            bus.BUSY <= 1'b0;
          end
        end

        GRANT1, GRANT2: begin
          if (!own_req || revoke) begin
            bus.GNT1 <= 1'b0;
            bus.GNT2 <= 1'b0;
            last     <= (state == GRANT2);
            if (other_req) begin
              // while granted, FS equals the holder's side, so the other side is ~FS
              state    <= SWITCH;
              bus.FS   <= ~bus.FS;
              tgt      <= ~bus.FS;
              bus.BUSY <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.BUSY <= 1'b0;
            end
          end else begin
`ifdef FMUX_ARB_TIMEOUT_EN
            if (other_req) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
`endif
          end
        end

        SWITCH: begin
          // dead cycle is over; grant the target only if it still wants the mux
          if (tgt_req) begin
            state    <= tgt ? GRANT2 : GRANT1;
            bus.GNT1 <= ~tgt;
            bus.GNT2 <= tgt;
            bus.BUSY <= 1'b1;
`ifdef FMUX_ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            state    <= IDLE;
            bus.BUSY <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.GNT1 <= 1'b0;
          bus.GNT2 <= 1'b0;
          bus.BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule
